// File: rtl/serial2tcp_line_framer_pkg.sv
// Shared types and helpers for the serial2tcp line framer.
package serial2tcp_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t TERM_DEFAULT = 8'h0A;

  // Pointer width for a circular buffer of 'depth' slots, including the wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serial2tcp_line_framer_if.sv
// Byte-stream sink and framed source handshakes of the line framer.
interface serial2tcp_line_framer_if;
  import serial2tcp_pkg::*;

  logic  sink_valid;
  logic  sink_ready;
  byte_t sink_data;
  logic  source_valid;
  logic  source_ready;
  byte_t source_data;
  logic  source_last;

  // The framer itself.
  modport slave (
    input  sink_valid, sink_data, source_ready,
    output sink_ready, source_valid, source_data, source_last
  );

  // Upstream producer and downstream consumer seen together.
  modport master (
    output sink_valid, sink_data, source_ready,
    input  sink_ready, source_valid, source_data, source_last
  );

endinterface

// File: rtl/serial2tcp_line_framer_timer.sv
// Idle counter: counts run cycles and pulses expire when TIMEOUT is reached.
module serial2tcp_framer_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expire in the cycle whose increment would reach TIMEOUT; the counter self-clears.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == LIMIT) begin
        expire_o = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial2tcp_line_framer.sv
// Line framer: buffers bytes and releases them only as whole frames
// (terminator, max length or idle timeout).
module serial2tcp_line_framer
  import serial2tcp_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MAX_LEN = 32,
  parameter byte_t       TERM    = TERM_DEFAULT,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  serial2tcp_line_framer_if.slave   bus,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  typedef logic [PW-1:0] ptr_t;

  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            cm_ptr_q, cm_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  byte_t           mem_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  logic            sink_ready;
  logic            source_valid;
  logic            sink_xfer;
  logic            src_xfer;
  logic            end_hit;
  logic            tmo_commit;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   prev_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign prev_idx = wr_idx - 1'b1;
  assign rd_idx   = rd_ptr_q[AW-1:0];

  assign sink_ready   = (wr_ptr_q - rd_ptr_q) != ptr_t'(DEPTH);
  assign source_valid = rd_ptr_q != cm_ptr_q;

  assign bus.sink_ready   = sink_ready;
  assign bus.source_valid = source_valid;
  assign bus.source_data  = mem_q[rd_idx];
  assign bus.source_last  = last_q[rd_idx];
  assign level            = wr_ptr_q - rd_ptr_q;

  assign sink_xfer = bus.sink_valid & sink_ready;
  assign src_xfer  = source_valid & bus.source_ready;
  assign end_hit   = sink_xfer &&
                     ((bus.sink_data == TERM) || (pend_cnt_q == CW'(MAX_LEN - 1)));

  // Idle timer runs only while a partial frame waits and no byte arrives,
  // so a timeout commit never coincides with a sink transfer.
  serial2tcp_framer_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .clear_i  (sink_xfer),
    .run_i    ((pend_cnt_q != '0) && !sink_xfer),
    .expire_o (tmo_commit)
  );

  // Pointer and pending-count next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_cnt_d = pend_cnt_q;
    if (sink_xfer) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (end_hit) begin
        cm_ptr_d   = wr_ptr_q + 1'b1;
        pend_cnt_d = '0;
      end else begin
        pend_cnt_d = pend_cnt_q + 1'b1;
      end
    end else if (tmo_commit) begin
      cm_ptr_d   = wr_ptr_q;
      pend_cnt_d = '0;
    end
    if (src_xfer) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer and pending-count registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Last flags: every write refreshes its slot's flag; a timeout marks the newest pending byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_q <= '0;
    end else if (sink_xfer) begin
      last_q[wr_idx] <= end_hit;
    end else if (tmo_commit) begin
      last_q[prev_idx] <= 1'b1;
    end
  end

  // Data storage, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (sink_xfer) mem_q[wr_idx] <= bus.sink_data;
  end

endmodule

// File: tb/tb_serial2tcp_line_framer.sv
// Directed and randomized checks for serial2tcp_line_framer (DEPTH 64, MAX_LEN 32, TIMEOUT 1000).
module tb_serial2tcp_line_framer;

  localparam int PW = 7;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [PW-1:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  serial2tcp_line_framer_if bus();

  serial2tcp_line_framer #(
    .DEPTH   (64),
    .MAX_LEN (32),
    .TERM    (8'h0A),
    .TIMEOUT (1000)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .level   (level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       sr;
    logic       exp_v;
    logic       exp_rdy;
    int         exp_lvl;
    logic       chk_d;
    logic [7:0] exp_d;
    logic       exp_last;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.sink_valid   = 1'b0;
    bus.sink_data    = 8'h00;
    bus.source_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [8:0] q [$];
    logic [8:0] ent;
    int         k;
    int         pend;
    int         sent;
    logic [7:0] rd;
    logic       is_last;

    idle_inputs();

    // Reset state while reset is held.
    @(negedge sys_clk);
    check("rst source_valid", bus.source_valid, 0);
    check("rst sink_ready", bus.sink_ready, 1);
    check("rst level", level, 0);
    sys_rst = 1'b0;

    // sv, d, sr, exp_v, exp_rdy, exp_lvl, chk_d, exp_d, exp_last
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 1'b1, 8'h41, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 1'b1, 8'h42, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b1, 8'h0A, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b1, 8'h0A, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 2, 1'b1, 8'h55, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 1'b1, 8'h0A, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};

    // Table: "AB\n", lone terminator, simultaneous read/write.
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      bus.sink_valid   = tbl[i].sv;
      bus.sink_data    = tbl[i].d;
      bus.source_ready = tbl[i].sr;
      check($sformatf("vec%0d source_valid", i), bus.source_valid, tbl[i].exp_v);
      check($sformatf("vec%0d sink_ready", i), bus.sink_ready, tbl[i].exp_rdy);
      check($sformatf("vec%0d level", i), level, tbl[i].exp_lvl);
      if (tbl[i].chk_d) begin
        check($sformatf("vec%0d data", i), bus.source_data, tbl[i].exp_d);
        check($sformatf("vec%0d last", i), bus.source_last, tbl[i].exp_last);
      end
    end

    // Max-length commit: 40 bytes, 32 committed, 8 pending.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      bus.sink_valid = 1'b1;
      bus.sink_data  = 8'(8'h80 + i);
    end
    @(negedge sys_clk);
    bus.sink_valid = 1'b0;
    check("maxlen level40", level, 40);
    check("maxlen valid", bus.source_valid, 1);
    bus.source_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("maxlen byte%0d", i), {bus.source_valid, bus.source_last, bus.source_data},
            {1'b1, (i == 31), 8'(8'h80 + i)});
      @(negedge sys_clk);
    end
    check("maxlen drained valid", bus.source_valid, 0);
    check("maxlen pending level", level, 8);

    // Idle timeout on a 5-byte partial frame.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      bus.sink_valid = 1'b1;
      bus.sink_data  = 8'(8'h30 + i);
    end
    @(negedge sys_clk);
    bus.sink_valid = 1'b0;
    k = 0;
    while (!bus.source_valid && k < 1100) begin
      @(negedge sys_clk);
      k++;
    end
    check("timeout cycles", k, 1000);
    check("timeout level", level, 5);
    bus.source_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("timeout byte%0d", i), {bus.source_valid, bus.source_last, bus.source_data},
            {1'b1, (i == 4), 8'(8'h30 + i)});
      @(negedge sys_clk);
    end
    check("timeout drained", bus.source_valid, 0);

    // Full buffer: 64 bytes, write blocked, simultaneous read at full.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      check($sformatf("full ready%0d", i), bus.sink_ready, 1);
      bus.sink_valid = 1'b1;
      bus.sink_data  = 8'(8'h80 + i);
    end
    @(negedge sys_clk);
    check("full sink_ready", bus.sink_ready, 0);
    check("full level", level, 64);
    bus.sink_data    = 8'hEE;
    bus.source_ready = 1'b1;
    check("full byte0", {bus.source_valid, bus.source_last, bus.source_data}, {1'b1, 1'b0, 8'h80});
    @(negedge sys_clk);
    bus.sink_valid = 1'b0;
    check("full level after read", level, 63);
    check("full ready after read", bus.sink_ready, 1);
    for (int i = 1; i < 64; i++) begin
      check($sformatf("full byte%0d", i), {bus.source_valid, bus.source_last, bus.source_data},
            {1'b1, (i == 31 || i == 63), 8'(8'h80 + i)});
      @(negedge sys_clk);
    end
    check("full drained valid", bus.source_valid, 0);
    check("full drained level", level, 0);

    // Asynchronous reset mid-frame, then "Z\n".
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      bus.sink_valid = 1'b1;
      bus.sink_data  = 8'(8'h20 + i);
    end
    @(negedge sys_clk);
    bus.sink_valid = 1'b0;
    check("arst pre level", level, 10);
    #2 sys_rst = 1'b1;
    #1;
    check("arst source_valid", bus.source_valid, 0);
    check("arst level", level, 0);
    check("arst sink_ready", bus.sink_ready, 1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    bus.sink_valid = 1'b1;
    bus.sink_data  = 8'h5A;
    @(negedge sys_clk);
    bus.sink_data  = 8'h0A;
    @(negedge sys_clk);
    bus.sink_valid   = 1'b0;
    bus.source_ready = 1'b1;
    check("arst Z", {bus.source_valid, bus.source_last, bus.source_data}, {1'b1, 1'b0, 8'h5A});
    @(negedge sys_clk);
    check("arst NL", {bus.source_valid, bus.source_last, bus.source_data}, {1'b1, 1'b1, 8'h0A});
    @(negedge sys_clk);
    check("arst done", bus.source_valid, 0);

    // Random traffic against a reference queue.
    do_reset();
    pend = 0;
    sent = 0;
    k    = 0;
    while (sent < 1000 && k < 20000) begin
      @(negedge sys_clk);
      k++;
      rd = 8'($urandom_range(0, 255));
      if (rd == 8'h0A) rd = 8'h0B;
      if ($urandom_range(0, 9) == 0) rd = 8'h0A;
      bus.sink_valid   = $urandom_range(0, 1) == 1;
      bus.sink_data    = rd;
      bus.source_ready = $urandom_range(0, 1) == 1;
      if (bus.source_valid && bus.source_ready) begin
        if (q.size() == 0) check("rand unexpected output", 1, 0);
        else begin
          ent = q.pop_front();
          check("rand byte", {bus.source_last, bus.source_data}, ent);
        end
      end
      if (bus.sink_valid && bus.sink_ready) begin
        is_last = (rd == 8'h0A) || (pend + 1 == 32);
        q.push_back({is_last, rd});
        pend = is_last ? 0 : pend + 1;
        sent++;
      end
    end
    check("rand all sent", sent, 1000);
    if (pend > 0) begin
      ent    = q[q.size() - 1];
      ent[8] = 1'b1;
      q[q.size() - 1] = ent;
    end
    k = 0;
    while ((q.size() > 0 || bus.source_valid) && k < 3000) begin
      @(negedge sys_clk);
      k++;
      bus.sink_valid   = 1'b0;
      bus.source_ready = 1'b1;
      if (bus.source_valid) begin
        if (q.size() == 0) check("rand unexpected output", 1, 0);
        else begin
          ent = q.pop_front();
          check("rand byte", {bus.source_last, bus.source_data}, ent);
        end
      end
    end
    check("rand drain done", q.size(), 0);
    @(negedge sys_clk);
    check("rand final level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial2tcp_line_framer.md
Name: serial2tcp_line_framer

Overview:
Byte-stream framing stage that sits directly upstream of serial2tcp_loopback's sink port.
- Accepts raw 8-bit bytes on a valid/ready sink.
- Buffers them and releases them on a valid/ready source only in whole frames, so the TCP side sends complete lines, not single-byte segments.
- A frame ends on a terminator byte, on reaching a maximum length, or after an idle timeout.

Parameters:
DEPTH, 64, buffer depth in bytes; power of two, >= 2
MAX_LEN, 32, maximum frame length in bytes; 1 <= MAX_LEN <= DEPTH
TERM, 8'h0A, terminator byte; it ends a frame and is itself forwarded as the last byte
TIMEOUT, 1000, idle cycles with pending bytes before a forced frame end; >= 1

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
sys_rst  input  1  asynchronous, active-high reset
sink_valid  input  1  upstream byte valid
sink_ready  output  1  framer can accept a byte
sink_data  input  8  upstream byte
source_valid  output  1  committed byte available
source_ready  input  1  downstream accepts byte
source_data  output  8  byte at the read pointer
source_last  output  1  current source byte is the final byte of its frame
level  output  $clog2(DEPTH)+1  bytes held, committed plus pending

Behaviour:
- Reset is asynchronous, active-high, on sys_clk.
- Storage is a circular buffer with three registered pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
  - wr_ptr: next write slot.
  - cm_ptr: end of committed data.
  - rd_ptr: next read slot.
- Per-slot last-flag register array, written independently of the data array.
- Handshakes:
  - Sink transfer: sink_valid & sink_ready.
  - Source transfer: source_valid & source_ready.
- sink_ready = (wr_ptr - rd_ptr) != DEPTH. It is registered-pointer based, with no combinational path from source_ready or sink_valid.
- source_valid = (rd_ptr != cm_ptr).
- source_data and source_last are read combinationally from the slot at rd_ptr. They must be held stable while source_valid=1 and source_ready=0.
- pend_cnt counts bytes written since the last commit, range 0..MAX_LEN.
- A commit sets cm_ptr to wr_ptr after the write, sets last for that final byte, and clears pend_cnt and the idle timer.
- Commit on an accepted byte when either holds:
  - the byte == TERM, or
  - pend_cnt+1 == MAX_LEN.
  The byte is written with last=1 in the same cycle.
- Idle timer:
  - Increments each cycle with pend_cnt>0 and no sink transfer.
  - Cleared by any sink transfer.
  - On reaching TIMEOUT: timeout commit. Sets last on slot wr_ptr-1, cm_ptr takes wr_ptr, pend_cnt and timer clear.
- Latency: a committing byte accepted in cycle N makes source_valid=1 in cycle N+1 at the earliest.
- A timeout commit can only occur in a cycle with no sink transfer; a sink transfer always takes priority.
- A source transfer advances rd_ptr; level = wr_ptr - rd_ptr.
- A simultaneous sink and source transfer in the same cycle is legal, including when the buffer is full: sink_ready is already 0 in that cycle, so no write occurs.
- Full with pending bytes cannot deadlock, because MAX_LEN <= DEPTH forces a commit no later than the DEPTH-th pending byte.
- Empty frame: none is possible. A TERM byte on its own forms a 1-byte frame with last=1.
- Pointer wrap-around is handled by the modular wrap bit only; no special case.
- Reset values, asserted asynchronously including mid-frame, with buffer contents discarded:
  - all pointers = 0, pend_cnt = 0, timer = 0, all last flags = 0
  - source_valid = 0, sink_ready = 1, level = 0
- There is no partial-frame replay after reset.

Decomposition:
- Package serial2tcp_pkg holds:
  - byte_t (8-bit typedef)
  - TERM_DEFAULT = 8'h0A
  - a ptr-width function clog2-based
- One natural sub-module: serial2tcp_framer_timer, the idle counter. It takes clear, run and TIMEOUT and produces a one-cycle expire pulse.
- The buffer and pointer logic stay in the top module.

Test Plan:
- Send "AB\n" (0x41,0x42,0x0A) with source_ready=1 -> no source_valid before the 0x0A is accepted; next cycle 3 bytes stream out, last=1 only on 0x0A; level returns to 0.
- Send 40 non-TERM bytes with MAX_LEN=32 and source_ready=0 -> 32 bytes committed with last on byte 32; 8 bytes pending; level=40.
- Send 5 bytes then idle with TIMEOUT=1000 -> source_valid rises 1000 cycles after the last accept (±1 per counter definition); byte 5 has last=1.
- Hold source_ready=0 and push 64 non-TERM bytes with DEPTH=64 and MAX_LEN=32 -> sink_ready=0 at level 64; two frames of 32; then release source_ready -> sink_ready returns 1 after the first read.
- Assert sys_rst asynchronously, between clock edges, mid-frame with level=10 -> source_valid=0, level=0 and sink_ready=1 immediately; the next frame "Z\n" is forwarded correctly.
- Run 1000 random bytes (10% TERM) with random valid and ready over multiple pointer wraps -> the output byte sequence equals the input sequence; last flags match the reference model.
